// File: rtl/operand_bypass.sv
// EX-stage operand bypass: selects each ALU source from the register file, the previous
// ALU result or returned load data, and stalls while a load-forwarded operand is outstanding.
module operand_bypass #(
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          load,
  input  logic          sr1,
  input  logic          sr2,
  input  logic          sr1_dr,
  input  logic          sr2_dr,
  input  logic [DW-1:0] rf_a,
  input  logic [DW-1:0] rf_b,
  input  logic [DW-1:0] alu_q,
  input  logic [DW-1:0] mem_q,
  input  logic          mem_valid,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic          stall,
  output logic [CW-1:0] fwd_alu_cnt,
  output logic [CW-1:0] fwd_mem_cnt,
  output logic          dbg_state
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] op_a_q, op_b_q;
  logic [CW-1:0] alu_cnt_q, mem_cnt_q;
  logic          hold_sr1_q, hold_sr2_q, hold_dr1_q, hold_dr2_q;
  logic [DW-1:0] hold_rf_a_q, hold_rf_b_q, hold_alu_q;

  logic          cur_sr1, cur_sr2, cur_dr1, cur_dr2;
  logic [DW-1:0] cur_rf_a, cur_rf_b, cur_alu;
  logic [DW-1:0] sel_a, sel_b;
  logic          in_wait, capture, go_wait;
  logic [1:0]    alu_add, mem_add;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] c, input logic [1:0] n);
    logic [CW:0] s;
    s = {1'b0, c} + {{(CW-1){1'b0}}, n};
    return s[CW] ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  assign in_wait = (state_q == ST_WAIT);

  // In WAIT the live flags and register reads belong to a later instruction, so the
  // selection is rebuilt from the snapshot taken when the load missed.
  always_comb begin
    cur_sr1  = in_wait ? hold_sr1_q  : sr1;
    cur_sr2  = in_wait ? hold_sr2_q  : sr2;
    cur_dr1  = in_wait ? hold_dr1_q  : sr1_dr;
    cur_dr2  = in_wait ? hold_dr2_q  : sr2_dr;
    cur_rf_a = in_wait ? hold_rf_a_q : rf_a;
    cur_rf_b = in_wait ? hold_rf_b_q : rf_b;
    cur_alu  = in_wait ? hold_alu_q  : alu_q;
  end

  always_comb begin
    sel_a   = cur_dr1 ? mem_q : (cur_sr1 ? cur_alu : cur_rf_a);
    sel_b   = cur_dr2 ? mem_q : (cur_sr2 ? cur_alu : cur_rf_b);
    alu_add = {1'b0, ~cur_dr1 & cur_sr1} + {1'b0, ~cur_dr2 & cur_sr2};
    mem_add = {1'b0, cur_dr1} + {1'b0, cur_dr2};
  end

  always_comb begin
    capture = 1'b0;
    go_wait = 1'b0;
    state_d = state_q;
    if (in_wait) begin
      capture = mem_valid;
      if (mem_valid) state_d = ST_RUN;
    end else if (load) begin
      if ((cur_dr1 | cur_dr2) && !mem_valid) begin
        go_wait = 1'b1;
        state_d = ST_WAIT;
      end else begin
        capture = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_RUN;
      op_a_q      <= '0;
      op_b_q      <= '0;
      alu_cnt_q   <= '0;
      mem_cnt_q   <= '0;
      hold_sr1_q  <= 1'b0;
      hold_sr2_q  <= 1'b0;
      hold_dr1_q  <= 1'b0;
      hold_dr2_q  <= 1'b0;
      hold_rf_a_q <= '0;
      hold_rf_b_q <= '0;
      hold_alu_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        op_a_q    <= sel_a;
        op_b_q    <= sel_b;
        alu_cnt_q <= sat_add(alu_cnt_q, alu_add);
        mem_cnt_q <= sat_add(mem_cnt_q, mem_add);
      end
      if (go_wait) begin
        hold_sr1_q  <= sr1;
        hold_sr2_q  <= sr2;
        hold_dr1_q  <= sr1_dr;
        hold_dr2_q  <= sr2_dr;
        hold_rf_a_q <= rf_a;
        hold_rf_b_q <= rf_b;
        hold_alu_q  <= alu_q;
      end
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign stall       = in_wait;
  assign fwd_alu_cnt = alu_cnt_q;
  assign fwd_mem_cnt = mem_cnt_q;
  assign dbg_state   = state_q[0];

endmodule

// File: tb/tb_operand_bypass.sv
// Bench for operand_bypass: directed cases from the plan, a random mix, counter saturation
// and reset during a pending load, checked against a queue of expected operand pairs.
module tb_operand_bypass;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          load, sr1, sr2, sr1_dr, sr2_dr, mem_valid;
  logic [DW-1:0] rf_a, rf_b, alu_q, mem_q;
  logic [DW-1:0] op_a, op_b;
  logic          stall, dbg_state;
  logic [CW-1:0] fwd_alu_cnt, fwd_mem_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*DW-1:0] exp_q[$];

  // reference state
  logic          m_wait;
  logic          m_s1, m_s2, m_d1, m_d2;
  logic [DW-1:0] m_ra, m_rb, m_alu;
  logic [CW-1:0] m_acnt, m_mcnt;
  int            stall_seen;

  operand_bypass #(.DW(DW), .CW(CW)) dut (
    .CLK(CLK), .RSTN(RSTN), .load(load), .sr1(sr1), .sr2(sr2),
    .sr1_dr(sr1_dr), .sr2_dr(sr2_dr), .rf_a(rf_a), .rf_b(rf_b),
    .alu_q(alu_q), .mem_q(mem_q), .mem_valid(mem_valid),
    .op_a(op_a), .op_b(op_b), .stall(stall),
    .fwd_alu_cnt(fwd_alu_cnt), .fwd_mem_cnt(fwd_mem_cnt), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] model_sat(input logic [CW-1:0] c, input int n);
    if (int'(c) > int'(CNT_MAX) - n) return CNT_MAX;
    return c + CW'(n);
  endfunction

  task automatic set_in(input logic ld, input logic s1, input logic s2, input logic d1,
                        input logic d2, input logic [DW-1:0] ra, input logic [DW-1:0] rb,
                        input logic [DW-1:0] aq, input logic [DW-1:0] mq, input logic mv);
    load = ld; sr1 = s1; sr2 = s2; sr1_dr = d1; sr2_dr = d2;
    rf_a = ra; rf_b = rb; alu_q = aq; mem_q = mq; mem_valid = mv;
  endtask

  task automatic model_reset();
    m_wait = 1'b0; m_acnt = '0; m_mcnt = '0;
    exp_q.delete();
  endtask

  // One clock: predict from the driven inputs, advance, then compare just after the edge.
  task automatic tick();
    logic f1, f2, g1, g2, cap;
    logic [DW-1:0] ra, rb, al, a, b;
    if (m_wait) begin
      f1 = m_d1; f2 = m_d2; g1 = m_s1; g2 = m_s2; ra = m_ra; rb = m_rb; al = m_alu;
      cap = mem_valid;
    end else begin
      f1 = sr1_dr; f2 = sr2_dr; g1 = sr1; g2 = sr2; ra = rf_a; rb = rf_b; al = alu_q;
      cap = load && (!(f1 || f2) || mem_valid);
      if (load && (f1 || f2) && !mem_valid) begin
        m_wait = 1'b1;
        m_d1 = f1; m_d2 = f2; m_s1 = g1; m_s2 = g2; m_ra = ra; m_rb = rb; m_alu = al;
      end
    end
    if (cap) begin
      a = f1 ? mem_q : (g1 ? al : ra);
      b = f2 ? mem_q : (g2 ? al : rb);
      exp_q.push_back({a, b});
      m_acnt = model_sat(m_acnt, int'(!f1 && g1) + int'(!f2 && g2));
      m_mcnt = model_sat(m_mcnt, int'(f1) + int'(f2));
      m_wait = 1'b0;
    end
    @(posedge CLK);
    #1;
    check_eq("stall", {31'b0, stall}, {31'b0, m_wait});
    if (stall) stall_seen++;
    if (cap) begin
      if (exp_q.size() == 0) begin
        check_eq("exp_queue_empty", 32'd1, 32'd0);
      end else begin
        logic [2*DW-1:0] e;
        e = exp_q.pop_front();
        check_eq("op_a", {16'b0, op_a}, {16'b0, e[2*DW-1:DW]});
        check_eq("op_b", {16'b0, op_b}, {16'b0, e[DW-1:0]});
      end
    end
    check_eq("fwd_alu_cnt", {16'b0, fwd_alu_cnt}, {16'b0, m_acnt});
    check_eq("fwd_mem_cnt", {16'b0, fwd_mem_cnt}, {16'b0, m_mcnt});
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    set_in(0, 0, 0, 0, 0, '0, '0, '0, '0, 0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
  endtask

  initial begin
    do_reset();
    check_eq("rst_op_a", {16'b0, op_a}, 32'h0);
    check_eq("rst_op_b", {16'b0, op_b}, 32'h0);
    check_eq("rst_stall", {31'b0, stall}, 32'h0);
    check_eq("rst_state", {31'b0, dbg_state}, 32'h0);
    check_eq("rst_alu_cnt", {16'b0, fwd_alu_cnt}, 32'h0);
    check_eq("rst_mem_cnt", {16'b0, fwd_mem_cnt}, 32'h0);

    set_in(1, 0, 0, 0, 0, 16'h0011, 16'h0022, 16'h0000, 16'h0000, 0);
    tick();
    check_eq("t1_op_a", {16'b0, op_a}, 32'h0011);
    check_eq("t1_op_b", {16'b0, op_b}, 32'h0022);

    set_in(1, 1, 0, 0, 0, 16'h0011, 16'h0022, 16'h1234, 16'h0000, 0);
    tick();
    check_eq("t2_op_a", {16'b0, op_a}, 32'h1234);
    check_eq("t2_op_b", {16'b0, op_b}, 32'h0022);
    check_eq("t2_alu_cnt", {16'b0, fwd_alu_cnt}, 32'd1);

    set_in(1, 0, 1, 0, 1, 16'h0011, 16'h0022, 16'h1234, 16'hBEEF, 1);
    tick();
    check_eq("t3_op_b", {16'b0, op_b}, 32'hBEEF);
    check_eq("t3_mem_cnt", {16'b0, fwd_mem_cnt}, 32'd1);
    check_eq("t3_alu_cnt", {16'b0, fwd_alu_cnt}, 32'd1);

    stall_seen = 0;
    set_in(1, 0, 0, 1, 0, 16'h0011, 16'h0022, 16'h1234, 16'h0000, 0);
    tick();
    set_in(1, 1, 1, 0, 0, 16'h5555, 16'h9999, 16'h7777, 16'h0000, 0);
    tick();
    tick();
    set_in(1, 1, 1, 0, 0, 16'h5555, 16'h9999, 16'h7777, 16'h00AA, 1);
    tick();
    check_eq("t4_stall_cycles", stall_seen, 32'd3);
    check_eq("t4_op_a", {16'b0, op_a}, 32'h00AA);
    check_eq("t4_op_b", {16'b0, op_b}, 32'h0022);
    check_eq("t4_stall_low", {31'b0, stall}, 32'h0);

    for (int i = 0; i < 60; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)));
      tick();
    end
    set_in(0, 0, 0, 0, 0, '0, '0, '0, '0, 1);
    tick();

    do_reset();
    for (int i = 0; i < 32767; i++) begin
      set_in(1, 1, 1, 0, 0, 16'($urandom), 16'($urandom), 16'($urandom), '0, 0);
      tick();
    end
    check_eq("sat_preload", {16'b0, fwd_alu_cnt}, 32'h0000FFFE);
    tick();
    check_eq("sat_reach_max", {16'b0, fwd_alu_cnt}, 32'h0000FFFF);
    tick();
    check_eq("sat_hold_max", {16'b0, fwd_alu_cnt}, 32'h0000FFFF);

    set_in(1, 0, 0, 0, 1, 16'h0101, 16'h0202, 16'h0303, '0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, '0, '0, '0, '0, 0);
    tick();
    #2;
    RSTN = 1'b0;
    model_reset();
    #1;
    check_eq("rst_wait_stall", {31'b0, stall}, 32'h0);
    check_eq("rst_wait_op_a", {16'b0, op_a}, 32'h0);
    check_eq("rst_wait_op_b", {16'b0, op_b}, 32'h0);
    check_eq("rst_wait_alu_cnt", {16'b0, fwd_alu_cnt}, 32'h0);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    set_in(0, 0, 0, 0, 0, '0, '0, '0, 16'hDEAD, 1);
    tick();
    tick();
    check_eq("post_rst_op_a", {16'b0, op_a}, 32'h0);
    check_eq("post_rst_op_b", {16'b0, op_b}, 32'h0);
    check_eq("post_rst_mem_cnt", {16'b0, fwd_mem_cnt}, 32'h0);
    check_eq("exp_queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_bypass.md
Name: operand_bypass

Overview:
- Execute-stage consumer of the forwarding flags (sr1, sr2, sr1_dr, sr2_dr).
- Selects each ALU source operand from one of three places: register-file read data, the previous ALU result, or returned load data (DR).
- Registers the selected operands into the EX operand registers.
- Stalls the pipeline while a DR-forwarded operand waits for memory, and keeps saturating forwarding-event counters.

Parameters:
- DW, 16, datapath width.
- CW, 16, width of each performance counter.

Ports:
- CLK  input  1  clock, rising-edge.
- RSTN  input  1  asynchronous active-low reset.
- load  input  1  pipeline advance enable; the same signal that drives the forwarding unit.
- sr1  input  1  operand A takes the previous ALU result.
- sr2  input  1  operand B takes the previous ALU result.
- sr1_dr  input  1  operand A takes load data.
- sr2_dr  input  1  operand B takes load data.
- rf_a  input  DW  register-file read for the SR1 field.
- rf_b  input  DW  register-file read for the SR2 field.
- alu_q  input  DW  registered ALU result of the previous instruction.
- mem_q  input  DW  load data from data memory.
- mem_valid  input  1  mem_q holds the load result this cycle.
- op_a  output  DW  registered EX operand A.
- op_b  output  DW  registered EX operand B.
- stall  output  1  freeze request to the fetch, decode and forwarding stages.
- fwd_alu_cnt  output  CW  count of operands taken from alu_q.
- fwd_mem_cnt  output  CW  count of operands taken from mem_q.

Behaviour:
- Reset (RSTN low, asynchronous): op_a = op_b = 0, stall = 0, both counters = 0, state = RUN, hold registers = 0.
- Per-operand source priority: DR flag first, then ALU flag, then register file.
  - Operand A: sr1_dr > sr1 > rf_a.
  - Operand B: sr2_dr > sr2 > rf_b.
  - Both flags set on one operand is legal; the DR flag wins.
- Flags are sampled in the cycle after the load edge that set them, alongside rf_a and rf_b for the same instruction.
- The selection is captured into op_a and op_b on the next rising edge where load = 1 (one-cycle latency).
- FSM has two states: RUN and WAIT.
- RUN, load = 0: all registers hold; stall = 0.
- RUN, load = 1, no DR flag set, or a DR flag set with mem_valid = 1:
  - op_a and op_b take the selected values (mem_q where a DR flag is set).
  - Stay in RUN.
- RUN, load = 1, any DR flag set, mem_valid = 0:
  - op_a and op_b are not updated.
  - Latch the non-DR operand's selected value, the two DR flags, and alu_q into hold registers.
  - Go to WAIT.
- WAIT:
  - stall = 1, combinationally from state.
  - load, the forwarding flags, rf_a and rf_b are ignored.
  - On the first cycle with mem_valid = 1: each latched-DR operand takes mem_q, the other takes its held value; stall drops the next cycle; return to RUN.
- WAIT has no timeout; memory must eventually assert mem_valid.
- If sr1_dr and sr2_dr are both set, both operands take the same mem_q value.
- Counters update on each edge where an operand is captured:
  - fwd_alu_cnt adds the number of operands (0, 1 or 2) whose final source is alu_q.
  - fwd_mem_cnt adds the number whose final source is mem_q.
  - Both saturate at 2^CW-1 and never wrap; an add of 2 from 2^CW-2 gives 2^CW-1.
- RSTN low in WAIT: immediate return to RUN with all reset values; the held operands are discarded.
- All arithmetic is unsigned.
- No combinational path from any data input to op_a or op_b.

Test Plan:
- Reset, then load = 1, no flags, rf_a = 16'h0011, rf_b = 16'h0022 -> next edge op_a = 16'h0011, op_b = 16'h0022, both counters 0, stall = 0.
- sr1 = 1, alu_q = 16'h1234, rf_a = 16'h0011 -> op_a = 16'h1234, op_b = rf_b, fwd_alu_cnt = 1.
- sr2_dr = 1, sr2 = 1, mem_valid = 1, mem_q = 16'hBEEF, alu_q = 16'h1234 -> op_b = 16'hBEEF (DR priority), fwd_mem_cnt = 1, fwd_alu_cnt unchanged.
- sr1_dr = 1, mem_valid low for 3 cycles, rf_b = 16'h0022 changed to 16'h9999 during the wait, then mem_q = 16'h00AA with mem_valid = 1:
  - stall high for exactly 3 cycles;
  - then op_a = 16'h00AA, op_b = 16'h0022 (held value, not 16'h9999);
  - stall low the following cycle.
- Preload fwd_alu_cnt to 2^CW-2, then sr1 = sr2 = 1 -> counter = 2^CW-1; a further forward leaves it at 2^CW-1.
- Enter WAIT, pulse RSTN low mid-wait -> stall = 0 and op_a = op_b = 0 immediately; a later mem_valid pulse has no effect.
